// File: rtl/op_loader_if.sv
// Byte-stream and SRAM-write bundle for the operand loader.
// The master side is the loader itself; the slave side is the byte source plus the SRAM.
interface op_loader_if #(
  parameter int ADRBW = 20,
  parameter int WRDBW = 16
);
  logic             i_byte_valid;
  logic [7:0]       i_byte;
  logic             o_byte_ready;
  logic             o_wen;
  logic [ADRBW-1:0] o_addr;
  logic [WRDBW-1:0] o_wdata;

  // A byte transfers on a rising edge where i_byte_valid and o_byte_ready are both high;
  // the source holds i_byte stable while valid is high and ready is low.
  modport master (
    input  i_byte_valid, i_byte,
    output o_byte_ready, o_wen, o_addr, o_wdata
  );

  modport slave (
    output i_byte_valid, i_byte,
    input  o_byte_ready, o_wen, o_addr, o_wdata
  );
endinterface

// File: rtl/op_loader.sv
// Packs an MS-byte-first operand stream into 16-bit words written LS word at base.
// Optional trailing zero guard word enabled by defining OP_LOADER_GUARD_EN.
module op_loader #(
  parameter int ADRBW = 20,
  parameter int WRDBW = 16,
  parameter int VARBW = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [VARBW-1:0] i_varsize,
  input  logic [ADRBW-1:0] i_baseaddr,
  op_loader_if.master      bus,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WR    = 3'd3,
    GUARD = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [ADRBW-1:0] ptr_q, ptr_d;
  logic [VARBW:0]   rem_q, rem_d;
  logic [7:0]       hi_q, hi_d;
  logic             ready_q, ready_d;
  logic             wen_q, wen_d;
  logic [ADRBW-1:0] addr_q, addr_d;
  logic [WRDBW-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef OP_LOADER_GUARD_EN
  logic [ADRBW-1:0] guard_q, guard_d;
`endif

  logic [VARBW:0] size_rnd;
  logic [VARBW:0] nwords;
  logic           accept;

  // Word count = ceil(bits/16); one extra bit keeps the rounding add from overflowing.
  assign size_rnd = {1'b0, i_varsize} + (VARBW+1)'(15);
  assign nwords   = size_rnd >> 4;
  assign accept   = ready_q && bus.i_byte_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef OP_LOADER_GUARD_EN
    guard_d = guard_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          ptr_d   = i_baseaddr + ADRBW'(nwords) - ADRBW'(1);
          rem_d   = nwords;
`ifdef OP_LOADER_GUARD_EN
          guard_d = i_baseaddr + ADRBW'(nwords);
`endif
          state_d = (nwords == '0) ? DONE : HI;
        end
      end
      HI: begin
        if (accept) begin
          hi_d    = bus.i_byte;
          state_d = LO;
        end
      end
      LO: begin
        // Write data is registered here so o_wen/o_addr/o_wdata line up in the WR cycle.
        if (accept) begin
          wen_d   = 1'b1;
          addr_d  = ptr_q;
          wdata_d = WRDBW'({hi_q, bus.i_byte});
          state_d = WR;
        end
      end
      WR: begin
        ptr_d = ptr_q - ADRBW'(1);
        rem_d = rem_q - (VARBW+1)'(1);
        if (rem_q != (VARBW+1)'(1)) begin
          state_d = HI;
        end else begin
`ifdef OP_LOADER_GUARD_EN
          wen_d   = 1'b1;
          addr_d  = guard_q;
          wdata_d = '0;
          state_d = GUARD;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef OP_LOADER_GUARD_EN
      GUARD:   state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == HI) || (state_d == LO);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OP_LOADER_GUARD_EN
      guard_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OP_LOADER_GUARD_EN
      guard_q <= guard_d;
`endif
    end
  end

  assign bus.o_byte_ready = ready_q;
  assign bus.o_wen        = wen_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_wdata      = wdata_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_op_loader.sv
// Directed self-checking bench for op_loader: write sequence, timing, backpressure,
// restart immunity, zero size, address wrap and asynchronous reset.
module tb_op_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [16:0] varsize;
  logic [19:0] baseaddr;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  op_loader_if #(.ADRBW(20), .WRDBW(16)) bus ();

  op_loader #(.ADRBW(20), .WRDBW(16), .VARBW(17)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_varsize   (varsize),
    .i_baseaddr  (baseaddr),
    .bus         (bus.master),
    .o_busy      (busy),
    .o_done      (done),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state: entries are {addr, data}
  logic [35:0] exp_q[$];
  logic [35:0] wr_q[$];
  logic [7:0]  bytes_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  int start_cyc = 0;
  logic busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (bus.o_wen) begin
      wr_q.push_back({bus.o_addr, bus.o_wdata});
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_start(input logic [16:0] vs, input logic [19:0] base);
    @(negedge clk);
    start = 1'b1;
    varsize = vs;
    baseaddr = base;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_stream(input int nb, input bit gaps, input bit inject, output int acc);
    int idx = 0;
    int budget = 0;
    bit v = 1'b0;
    bit rdy;
    bit injected = 1'b0;
    while (idx < nb && budget < 300) begin
      @(negedge clk);
      if (done) break;
      v = gaps ? ~v : 1'b1;
      bus.i_byte_valid = v;
      bus.i_byte = bytes_q[idx];
      if (inject && idx == 2 && !injected) begin
        start = 1'b1;
        varsize = 17'd64;
        baseaddr = 20'd100;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      rdy = bus.o_byte_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      budget++;
    end
    #1;
    bus.i_byte_valid = 1'b0;
    start = 1'b0;
    acc = idx;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_done_timeout got no o_done want o_done within 60 cycles", name);
    end
  endtask

  task automatic add_guard(input logic [19:0] gaddr);
`ifdef OP_LOADER_GUARD_EN
    exp_q.push_back({gaddr, 16'h0000});
`else
    if (gaddr === 20'hxxxxx) exp_q.push_back('0);
`endif
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_byte_ready, bus.o_wen, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {bus.o_byte_ready, bus.o_wen, busy, done});
    end
    checks++;
    if ({bus.o_addr, bus.o_wdata, dbg_state} !== 39'h0) begin
      errors++;
      $display("FAIL reset_bus got addr %h data %h state %0d want 0 0 0", bus.o_addr, bus.o_wdata, dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int acc;
    int d0 = done_cnt;
    wr_q.delete(); exp_q.delete();
    bytes_q = '{8'h98, 8'h44, 8'h47, 8'h5A};
    exp_q.push_back({20'd1, 16'h9844});
    exp_q.push_back({20'd0, 16'h475A});
    add_guard(20'd2);
    do_start(17'd32, 20'd0);
    send_stream(4, 1'b0, 1'b0, acc);
    wait_done(d0, "basic");
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_write%0d got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_latency got cycle %0d want %0d", done_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (busy_at_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_at_done got %b want 1", busy_at_done);
    end
    @(negedge clk);
    checks++;
    if ({busy, bus.o_byte_ready, bus.o_wen} !== 3'b000) begin
      errors++;
      $display("FAIL basic_idle_flags got %b want 000", {busy, bus.o_byte_ready, bus.o_wen});
    end
    checks++;
    if ({bus.o_addr, bus.o_wdata} !== exp_q[exp_q.size()-1]) begin
      errors++;
      $display("FAIL basic_hold got %h want %h", {bus.o_addr, bus.o_wdata}, exp_q[exp_q.size()-1]);
    end
  endtask

  task automatic test_odd_size();
    int acc;
    int d0 = done_cnt;
    wr_q.delete(); exp_q.delete();
    bytes_q = '{8'h00, 8'h00, 8'h04, 8'h57, 8'h00, 8'h0F};
    exp_q.push_back({20'd6, 16'h0000});
    exp_q.push_back({20'd5, 16'h0457});
    add_guard(20'd7);
    do_start(17'd17, 20'd5);
    send_stream(6, 1'b0, 1'b0, acc);
    wait_done(d0, "odd");
    repeat (4) @(negedge clk);
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL odd_accepted got %0d bytes want 4", acc);
    end
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL odd_count got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL odd_write%0d got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int d0 = done_cnt;
    wr_q.delete(); exp_q.delete();
    bytes_q = '{8'h98, 8'h44, 8'h47, 8'h5A};
    exp_q.push_back({20'd1, 16'h9844});
    exp_q.push_back({20'd0, 16'h475A});
    add_guard(20'd2);
    do_start(17'd32, 20'd0);
    send_stream(4, 1'b1, 1'b0, acc);
    wait_done(d0, "bp");
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_write%0d got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int acc;
    int d0 = done_cnt;
    wr_q.delete(); exp_q.delete();
    bytes_q = '{8'hC3, 8'h01, 8'hBE, 8'hEF};
    exp_q.push_back({20'h00000, 16'hC301});
    exp_q.push_back({20'hFFFFF, 16'hBEEF});
    add_guard(20'h00001);
    do_start(17'd32, 20'hFFFFF);
    send_stream(4, 1'b0, 1'b0, acc);
    wait_done(d0, "wrap");
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_write%0d got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef OP_LOADER_GUARD_EN
  task automatic test_guard();
    int acc;
    int d0 = done_cnt;
    wr_q.delete(); exp_q.delete();
    bytes_q = '{8'h12, 8'h34};
    exp_q.push_back({20'd10, 16'h1234});
    exp_q.push_back({20'd11, 16'h0000});
    do_start(17'd16, 20'd10);
    send_stream(2, 1'b0, 1'b0, acc);
    wait_done(d0, "guard");
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL guard_count got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL guard_write%0d got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL guard_done_latency got cycle %0d want %0d", done_cyc, last_wr_cyc + 1);
    end
  endtask
`endif

  task automatic test_restart_ignored();
    int acc;
    int d0 = done_cnt;
    wr_q.delete(); exp_q.delete();
    bytes_q = '{8'h98, 8'h44, 8'h47, 8'h5A};
    exp_q.push_back({20'd1, 16'h9844});
    exp_q.push_back({20'd0, 16'h475A});
    add_guard(20'd2);
    do_start(17'd32, 20'd0);
    send_stream(4, 1'b0, 1'b1, acc);
    wait_done(d0, "restart");
    repeat (10) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL restart_count got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL restart_write%0d got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_single_op got %0d dones busy %b want 1 dones busy 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_zero();
    int d0 = done_cnt;
    wr_q.delete();
    do_start(17'd0, 20'd7);
    wait_done(d0, "zero");
    repeat (3) @(negedge clk);
    checks++;
    if (done_cyc != start_cyc + 1) begin
      errors++;
      $display("FAIL zero_done_latency got cycle %0d want %0d", done_cyc, start_cyc + 1);
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_writes got %0d want 0", wr_q.size());
    end
    checks++;
    if (busy_at_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy_at_done got %b want 1", busy_at_done);
    end
  endtask

  task automatic test_midreset();
    int acc;
    int d0;
    wr_q.delete(); exp_q.delete();
    bytes_q = '{8'h98, 8'h44, 8'h47, 8'h5A};
    do_start(17'd32, 20'd0);
    send_stream(3, 1'b0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_byte_ready, bus.o_wen, busy, done, bus.o_addr, bus.o_wdata, dbg_state} !== 43'h0) begin
      errors++;
      $display("FAIL midreset_outputs got rdy %b wen %b busy %b done %b addr %h data %h state %0d want all 0",
               bus.o_byte_ready, bus.o_wen, busy, done, bus.o_addr, bus.o_wdata, dbg_state);
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {20'd1, 16'h9844}) begin
      errors++;
      $display("FAIL midreset_prior_writes got %0d writes want 1 of %h", wr_q.size(), {20'd1, 16'h9844});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    wr_q.delete();
    bytes_q = '{8'hAB, 8'hCD};
    exp_q.push_back({20'd3, 16'hABCD});
    add_guard(20'd4);
    do_start(17'd16, 20'd3);
    send_stream(2, 1'b0, 1'b0, acc);
    wait_done(d0, "postreset");
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL postreset_count got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL postreset_write%0d got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    varsize = '0;
    baseaddr = '0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte = '0;
    test_reset();
    test_basic();
    test_odd_size();
    test_backpressure();
    test_wrap();
`ifdef OP_LOADER_GUARD_EN
    test_guard();
`endif
    test_restart_ignored();
    test_zero();
    test_midreset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_loader.md
# op_loader

Operand loader that sits directly upstream of the multi-word adder. Accepts a big-integer operand as a byte stream, most-significant byte first, packs bytes into WRDBW-bit words and writes them into the shared operand SRAM, least-significant word at the base address, so that the adder can read the operand unchanged. Pulses `o_done` when the last word is written; the controller then loads the next operand or issues `i_valid` to the adder.

## Interface

- `ADRBW`, 20, SRAM address width
- `WRDBW`, 16, SRAM word width; fixed at 2 bytes per word
- `VARBW`, 17, width of the operand-size field, in bits

- `i_clk`  in  1  clock; all state changes on the rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  one-cycle start strobe; sampled only in IDLE
- `i_varsize`  in  VARBW  operand size in bits; sampled with `i_start`
- `i_baseaddr`  in  ADRBW  SRAM address of least-significant word; sampled with `i_start`
- `i_byte_valid`  in  1  byte present on `i_byte`
- `i_byte`  in  8  stream byte, MS byte of the operand first
- `o_byte_ready`  out  1  loader accepts `i_byte` this cycle
- `o_wen`  out  1  SRAM write enable, one cycle per word
- `o_addr`  out  ADRBW  SRAM write address
- `o_wdata`  out  WRDBW  SRAM write data
- `o_busy`  out  1  high from the cycle after an accepted start to the cycle of `o_done`, inclusive
- `o_done`  out  1  one-cycle completion pulse

## Operation

- Word count: N = ceil(`i_varsize` / 16), computed from the sampled size. Byte count = 2N. Bytes beyond `i_varsize` bits are still consumed and written; the host pads them with zeros.
- A byte is accepted in any cycle where `i_byte_valid` and `o_byte_ready` are both high.
- States:
  - IDLE: `o_byte_ready`=0. On `i_start`, latch the fields and set the word pointer to base+N-1. Go to DONE if N=0, otherwise go to HI.
  - HI: `o_byte_ready`=1. On accept, place the byte into the high half of the pack register and go to LO.
  - LO: `o_byte_ready`=1. On accept, place the byte into the low half and go to WR.
  - WR: `o_byte_ready`=0. Drive `o_wen`=1, `o_addr`=pointer and `o_wdata`=pack. Decrement the pointer and the remaining-word counter.
    - If words remain, go to HI.
    - Otherwise, go to GUARD if `OP_LOADER_GUARD_EN` is defined, else go to DONE.
  - GUARD: `o_wen`=1, `o_addr`=base+N, `o_wdata`=0. Go to DONE.
  - DONE: `o_done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic wraps modulo 2^ADRBW.
- `i_start` is ignored outside IDLE.
- Bytes presented while `o_byte_ready`=0 are not consumed; the source holds them.

## Timing

- Reset values:
  - state IDLE
  - `o_byte_ready`=0, `o_wen`=0, `o_addr`=0, `o_wdata`=0
  - `o_busy`=0, `o_done`=0
- All outputs are registered or decoded from state only; no combinational path from `i_byte_valid` to `o_byte_ready`.
- Latency: `o_wen` is asserted in the cycle after the low byte is accepted. The next high byte can be accepted in the cycle after the write.
- Full throughput is 2 bytes per 3 cycles.
- `o_done` is asserted in the cycle after the final write, which is the WR write or the GUARD write. For N=0, `o_done` is asserted in the cycle after `i_start`.
- `o_addr` and `o_wdata` hold their last values when `o_wen`=0.
- Reset mid-operation: returns immediately to IDLE. No write completes. Partially written SRAM contents are left as they are. A partial pack register is discarded.

## Configuration

- `OP_LOADER_GUARD_EN`:
  - Defined: after the last operand word, write one zero word at base+N. This clears the carry/guard word the adder reads past the operand, at a cost of one extra cycle.
  - Undefined: GUARD state is absent. `o_done` follows the last data write directly, and address base+N is never touched.

## Test plan

- varsize=32, base=0, bytes 98,44,47,5A with no gaps -> addr1←9844, addr0←475A. `o_done` is asserted 1 cycle after the 2nd write. No other writes occur (guard off).
- varsize=17, base=5, bytes 00,00,04,57,00,0F -> N=2: addr6←0000, addr5←0457. The last 2 bytes are never accepted, because `o_byte_ready` stays 0 after DONE.
- Backpressure: same stream as the first scenario, with `i_byte_valid` toggling every other cycle -> identical writes and addresses. No byte is lost or duplicated.
- Guard enabled: varsize=16, base=10, bytes 12,34 -> addr10←1234, then addr11←0000, then `o_done`.
- `i_start` pulsed again while busy, with varsize=64 -> ignored; the first operation completes unchanged.
- `i_rst_n` low after the high byte of word 2 is accepted -> all outputs are at reset values asynchronously. A new start after reset behaves as from fresh.
- varsize=0 -> no `o_wen`; `o_done` is asserted 1 cycle after `i_start`.
